// File: rtl/id_operand_stage.sv
// RV32I decode/operand stage in front of the ALU.
// It reads the register file and tracks in-flight destinations, stalling reads of pending results.
module id_operand_stage #(
   parameter int XLEN       = 32,
   parameter bit RESET_REGS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] alu_d1,
   output logic [XLEN-1:0] alu_d2,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rd;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign funct7 = in_instr[31:25];

   logic [XLEN-1:0] regs_q [32];
   logic [XLEN-1:0] regs_d [32];
   logic [31:0]     busy_q;
   logic [31:0]     busy_d;

   logic            out_valid_q, out_valid_d;
   logic [3:0]      alu_op_q, alu_op_d;
   logic [XLEN-1:0] alu_d1_q, alu_d1_d;
   logic [XLEN-1:0] alu_d2_q, alu_d2_d;
   logic [4:0]      out_rd_q, out_rd_d;
   logic            out_illegal_q, out_illegal_d;

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt_imm;
   logic [XLEN-1:0] shamt_reg;

   logic [3:0]      base_op;
   logic [3:0]      dec_op;
   logic [XLEN-1:0] dec_d1;
   logic [XLEN-1:0] dec_d2;
   logic            dec_legal;
   logic            use_rs1;
   logic            use_rs2;
   logic            hazard;
   logic            accept;

   // Register file: a write-back in the same cycle as the read is forwarded.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != 5'd0) begin
         rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs_q[rs1];
      end
      if (rs2 != 5'd0) begin
         rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs_q[rs2];
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (wb_en && wb_rd != 5'd0) begin
         regs_d[wb_rd] = wb_data;
      end
   end

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            always_ff @(posedge clk) begin
               regs_q[gi] <= '0;
            end
         end else if (RESET_REGS) begin : g_rst
            always_ff @(posedge clk) begin
               if (rst) begin
                  regs_q[gi] <= '0;
               end else begin
                  regs_q[gi] <= regs_d[gi];
               end
            end
         end else begin : g_norst
            always_ff @(posedge clk) begin
               regs_q[gi] <= regs_d[gi];
            end
         end
      end
   endgenerate

   assign imm_i     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign imm_u     = XLEN'({in_instr[31:12], 12'b0});
   assign shamt_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
   assign shamt_reg = {{(XLEN-5){1'b0}}, rs2_val[4:0]};

   // funct3 selects the same operation family for OP and OP-IMM.
   always_comb begin
      base_op = ALU_ADD;
      case (funct3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   end

   always_comb begin
      dec_op    = ALU_ADD;
      dec_d1    = '0;
      dec_d2    = '0;
      dec_legal = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               dec_legal = 1'b1;
               dec_op    = base_op;
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               dec_legal = 1'b1;
               dec_op    = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               dec_legal = 1'b1;
               dec_op    = ALU_SRA;
            end
            use_rs1 = dec_legal;
            use_rs2 = dec_legal;
            dec_d1  = rs1_val;
            dec_d2  = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_reg : rs2_val;
         end
         OPC_OPIMM: begin
            dec_op = base_op;
            dec_d1 = rs1_val;
            dec_d2 = imm_i;
            if (funct3 == 3'b001) begin
               dec_legal = (funct7 == F7_BASE);
               dec_d2    = shamt_imm;
            end else if (funct3 == 3'b101) begin
               dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               dec_d2    = shamt_imm;
            end else begin
               dec_legal = 1'b1;
            end
            use_rs1 = dec_legal;
         end
         OPC_LUI: begin
            dec_legal = 1'b1;
            dec_d2    = imm_u;
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
      // Unsupported encodings present as a harmless ADD of zeros.
      if (!dec_legal) begin
         dec_op = ALU_ADD;
         dec_d1 = '0;
         dec_d2 = '0;
      end
   end

   always_comb begin
      hazard = (use_rs1 && busy_q[rs1] && !(wb_en && wb_rd == rs1)) ||
               (use_rs2 && busy_q[rs2] && !(wb_en && wb_rd == rs2));
   end

   assign in_ready = !hazard && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Set beats clear so a producer issued in its predecessor's write-back cycle stays pending.
   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_rd] = 1'b0;
      end
      if (accept && dec_legal && rd != 5'd0) begin
         busy_d[rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      alu_op_d      = alu_op_q;
      alu_d1_d      = alu_d1_q;
      alu_d2_d      = alu_d2_q;
      out_rd_d      = out_rd_q;
      out_illegal_d = out_illegal_q;
      if (accept) begin
         out_valid_d   = 1'b1;
         alu_op_d      = dec_op;
         alu_d1_d      = dec_d1;
         alu_d2_d      = dec_d2;
         out_rd_d      = dec_legal ? rd : 5'd0;
         out_illegal_d = !dec_legal;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q        <= '0;
         out_valid_q   <= 1'b0;
         alu_op_q      <= ALU_ADD;
         alu_d1_q      <= '0;
         alu_d2_q      <= '0;
         out_rd_q      <= '0;
         out_illegal_q <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         out_valid_q   <= out_valid_d;
         alu_op_q      <= alu_op_d;
         alu_d1_q      <= alu_d1_d;
         alu_d2_q      <= alu_d2_d;
         out_rd_q      <= out_rd_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign alu_op      = alu_op_q;
   assign alu_d1      = alu_d1_q;
   assign alu_d2      = alu_d2_q;
   assign out_rd      = out_rd_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios then random traffic against an architectural model.
module tb_id_operand_stage;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [6:0] OP    = 7'b0110011;
   localparam logic [6:0] OPIMM = 7'b0010011;
   localparam logic [6:0] LUI   = 7'b0110111;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  alu_op;
   logic [31:0] alu_d1;
   logic [31:0] alu_d2;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int checks = 0;
   int failures = 0;

   exp_t        exp_q[$];
   logic [31:0] m_regs[32];
   logic [31:0] m_busy = '0;
   bit          m_ov = 1'b0;

   id_operand_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_op(alu_op), .alu_d1(alu_d1), .alu_d2(alu_d2),
      .out_rd(out_rd), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] opc);
      return {f7, s2, s1, f3, d, opc};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] opc);
      return {imm, s1, f3, d, opc};
   endfunction

   // Architectural register read as seen by an instruction in this cycle.
   function automatic logic [31:0] mread(input logic [4:0] r, input logic we, input logic [4:0] wr,
                                         input logic [31:0] wd);
      if (r == 5'd0) return 32'd0;
      if (we && wr == r) return wd;
      return m_regs[r];
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                       output bit u1, output bit u2);
      logic [3:0] f3_ops[8];
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      exp_t e;
      f3_ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      opc = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      e = '{op: ALU_ADD, d1: 32'd0, d2: 32'd0, rd: 5'd0, ill: 1'b1};
      u1 = 1'b0;
      u2 = 1'b0;
      if (opc == OP) begin
         if (f7 == 7'h00) begin
            e.ill = 1'b0;
            e.op = f3_ops[f3];
         end else if (f7 == 7'h20 && f3 == 3'd0) begin
            e.ill = 1'b0;
            e.op = ALU_SUB;
         end else if (f7 == 7'h20 && f3 == 3'd5) begin
            e.ill = 1'b0;
            e.op = ALU_SRA;
         end
         if (!e.ill) begin
            u1 = 1'b1;
            u2 = 1'b1;
            e.d1 = a;
            e.d2 = (f3 == 3'd1 || f3 == 3'd5) ? (b % 32) : b;
         end
      end else if (opc == OPIMM) begin
         e.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
         if (!e.ill) begin
            u1 = 1'b1;
            e.op = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : f3_ops[f3];
            e.d1 = a;
            e.d2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
         end
      end else if (opc == LUI) begin
         e.ill = 1'b0;
         e.d2 = ins & 32'hFFFF_F000;
      end
      if (!e.ill) e.rd = ins[11:7];
      return e;
   endfunction

   // One clock cycle of stimulus; predicts handshake and pushes the expected result on accept.
   task automatic step(input logic v, input logic [31:0] ins, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic ordy, input logic r);
      exp_t e;
      bit u1, u2, haz, exp_ready, acc;
      in_valid = v;
      in_instr = ins;
      wb_en = we;
      wb_rd = wr;
      wb_data = wd;
      out_ready = ordy;
      rst = r;
      #1;
      e = ref_decode(ins, mread(ins[19:15], we, wr, wd), mread(ins[24:20], we, wr, wd), u1, u2);
      haz = (u1 && m_busy[ins[19:15]] && !(we && wr == ins[19:15])) ||
            (u2 && m_busy[ins[24:20]] && !(we && wr == ins[24:20]));
      exp_ready = !haz && (!m_ov || ordy);
      acc = v && exp_ready && !r;
      if (!r) begin
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
      end
      if (acc) begin
         exp_q.push_back(e);
         $display("issue instr=%h op=%0d d1=%h d2=%h rd=%0d ill=%0b", ins, e.op, e.d1, e.d2, e.rd, e.ill);
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_busy = '0;
         m_ov = 1'b0;
         exp_q.delete();
      end else begin
         if (we && wr != 5'd0) m_regs[wr] = wd;
         if (we) m_busy[wr] = 1'b0;
         if (acc && !e.ill && e.rd != 5'd0) m_busy[e.rd] = 1'b1;
         m_ov = acc ? 1'b1 : (ordy ? 1'b0 : m_ov);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, ordy, 1'b0);
   endtask

   function automatic logic [6:0] pick_f7();
      int s;
      s = $urandom_range(0, 5);
      if (s < 4) return 7'h00;
      if (s == 4) return 7'h20;
      return 7'($urandom);
   endfunction

   function automatic logic [31:0] rand_instr();
      int k;
      logic [4:0] s1, s2, d;
      logic [2:0] f3;
      logic [11:0] imm;
      k = $urandom_range(0, 9);
      s1 = 5'($urandom_range(0, 7));
      s2 = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7));
      f3 = 3'($urandom);
      imm = 12'($urandom);
      if (k < 4) return enc_r(pick_f7(), s2, s1, f3, d, OP);
      if (k < 8) begin
         if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = pick_f7();
         return enc_i(imm, s1, f3, d, OPIMM);
      end
      if (k == 8) return {20'($urandom), d, LUI};
      return $urandom;
   endfunction

   // Monitor: pops an expectation whenever the consumer takes an output, and checks holding while stalled.
   initial begin
      exp_t e;
      exp_t snap;
      bit held;
      held = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               checks++;
               if ({alu_op, alu_d1, alu_d2, out_rd, out_illegal} !== snap) begin
                  failures++;
                  $display("FAIL hold: got %h expected %h", {alu_op, alu_d1, alu_d2, out_rd, out_illegal}, snap);
               end
            end
            if (out_valid && out_ready) begin
               held = 1'b0;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL spurious_output: op=%0d d1=%h d2=%h rd=%0d required no output", alu_op, alu_d1, alu_d2, out_rd);
               end else begin
                  e = exp_q.pop_front();
                  if ({alu_op, alu_d1, alu_d2, out_rd, out_illegal} !== e) begin
                     failures++;
                     $display("FAIL result: got op=%0d d1=%h d2=%h rd=%0d ill=%0b expected op=%0d d1=%h d2=%h rd=%0d ill=%0b",
                              alu_op, alu_d1, alu_d2, out_rd, out_illegal, e.op, e.d1, e.d2, e.rd, e.ill);
                  end else begin
                     $display("retire op=%0d d1=%h d2=%h rd=%0d ill=%0b", alu_op, alu_d1, alu_d2, out_rd, out_illegal);
                  end
               end
            end else if (out_valid) begin
               held = 1'b1;
               snap = {alu_op, alu_d1, alu_d2, out_rd, out_illegal};
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] add_x2_x1_x1;
      add_x2_x1_x1 = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2, OP);
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      @(negedge clk);
      step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
      chk("rst_alu_d1", alu_d1, 32'd0);
      chk("rst_alu_d2", alu_d2, 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
      @(negedge clk);

      // ADDI x1,x0,-5, then a dependent ADD that waits for x1's write-back.
      step(1'b1, 32'hFFB0_0093, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, add_x2_x1_x1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, add_x2_x1_x1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, add_x2_x1_x1, 1'b1, 5'd1, 32'd7, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 5'd2, 32'd14, 1'b1, 1'b0);

      // Shift-immediates on x1 = 0x80000000, plus an illegal SLLI.
      step(1'b0, 32'd0, 1'b1, 5'd1, 32'h8000_0000, 1'b1, 1'b0);
      step(1'b1, enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd3, OPIMM), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, enc_i({7'h00, 5'd4}, 5'd1, 3'd5, 5'd4, OPIMM), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, enc_i({7'h20, 5'd4}, 5'd1, 3'd1, 5'd5, OPIMM), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 5'd3, 32'd1, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 5'd4, 32'd2, 1'b1, 1'b0);

      // Consumer back-pressure for three cycles with a second instruction waiting.
      step(1'b1, enc_i(12'd1, 5'd0, 3'd0, 5'd0, OPIMM), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, enc_i(12'd2, 5'd0, 3'd0, 5'd0, OPIMM), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(1'b1, enc_i(12'd2, 5'd0, 3'd0, 5'd0, OPIMM), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      idle(1'b1);

      // LUI, then writes to x0 never make x0 non-zero or busy.
      step(1'b1, {20'h12345, 5'd5, LUI}, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
      step(1'b1, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6, OP), 1'b1, 5'd0, 32'h1234_5678, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 5'd5, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 5'd6, 32'd0, 1'b1, 1'b0);

      // Reset while a dependent instruction is stalled.
      step(1'b1, enc_i(12'd3, 5'd0, 3'd0, 5'd1, OPIMM), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(1'b1, add_x2_x1_x1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(1'b1, add_x2_x1_x1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      step(1'b1, add_x2_x1_x1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 5'd2, 32'd0, 1'b1, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         logic r;
         r = ($urandom_range(0, 199) == 0);
         step(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), $urandom, r ? 1'b0 : 1'($urandom_range(0, 3) != 0), r);
      end

      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
